// File: rtl/crazy_input_cond_pkg.sv
// Shared definitions for the CRAZYBALLOON input conditioner.
// Holds the joystick bit map, the coin FSM state type, idle output bytes
// and the opposing-direction cleaning helper.
package crazy_input_pkg;

  // Bit positions inside the raw MiSTer joystick words (active-high).
  localparam int JOY_R    = 0;
  localparam int JOY_L    = 1;
  localparam int JOY_D    = 2;
  localparam int JOY_U    = 3;
  localparam int JOY_S1   = 4;
  localparam int JOY_S2   = 5;
  localparam int JOY_COIN = 6;

  typedef enum logic [1:0] {
    C_IDLE  = 2'd0,
    C_PULSE = 2'd1,
    C_GAP   = 2'd2
  } coin_state_t;

  // Nothing pressed: every active-low bit high, IN1[7:6] low.
  localparam logic [7:0] IN0_IDLE = 8'hFF;
  localparam logic [7:0] IN1_IDLE = 8'h3F;

  // Opposing pair cleaning: both pressed means neither is pressed.
  function automatic logic [1:0] socd_pair(input logic a, input logic b);
    logic [1:0] res;
    if (a & b) begin
      res = 2'b00;
    end else begin
      res = {a, b};
    end
    return res;
  endfunction

endpackage

// File: rtl/crazy_input_cond_debounce.sv
// One-bit debouncer.
// The stable output follows the raw input only after the raw value has
// disagreed with it for DEBOUNCE_CYCLES consecutive clocks; any shorter
// disagreement is forgotten.
// Ports:
//   i_clk     clock
//   i_rst_n   async active-low reset (stable and counter cleared)
//   i_raw     raw input bit
//   o_stable  debounced bit
module input_debounce #(
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_stable
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] r_cnt;
  logic          r_stable;

  // Disagreement counter and stable value update.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= CNT_ZERO;
      r_stable <= 1'b0;
    end else if (i_raw == r_stable) begin
      r_cnt    <= CNT_ZERO;
    end else if (r_cnt == CNT_LAST) begin
      r_stable <= i_raw;
      r_cnt    <= CNT_ZERO;
    end else begin
      r_cnt    <= r_cnt + CNT_ONE;
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/crazy_input_cond.sv
// CRAZYBALLOON input conditioner: turns raw MiSTer joystick words into the
// active-low IN0/IN1 bytes of the core.
// Debounces 11 bits, cancels opposing directions, and converts coin presses
// into frame-timed pulses through a small saturating press queue.
// Ports:
//   CLK          clk_sys
//   RESET_N      async active-low reset
//   I_JOY1       joystick_0: [0]R [1]L [2]D [3]U [4]Start1 [5]Start2 [6]Coin
//   I_JOY2       joystick_1: [0]R [1]L [2]D [3]U
//   I_VBLANK     core vertical blank, synchronous to CLK
//   O_IN0        [3:0] = ~P1{U,D,L,R}, [7:4] = ~P2{U,D,L,R}
//   O_IN1        {1'b0, coin, ~Start2, ~Start1, 4'b1111}
//   O_COIN_BUSY  coin pulse in progress or presses still queued
module crazy_input_cond
  import crazy_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 1024,
  parameter int COIN_PULSE_FRAMES = 3,
  parameter int COIN_GAP_FRAMES   = 3,
  parameter int COIN_QUEUE_MAX    = 3
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [15:0] I_JOY1,
  input  logic [15:0] I_JOY2,
  input  logic        I_VBLANK,
  output logic [7:0]  O_IN0,
  output logic [7:0]  O_IN1,
  output logic        O_COIN_BUSY
);

  localparam int NBITS = 11;
  // Debounced vector layout: [3:0] P1 R/L/D/U, [7:4] P2 R/L/D/U,
  // [8] Start1, [9] Start2, [10] Coin.
  localparam int B_S1   = 8;
  localparam int B_S2   = 9;
  localparam int B_COIN = 10;

  localparam int FW = 8;
  localparam logic [FW-1:0] PULSE_LAST = FW'(COIN_PULSE_FRAMES - 1);
  localparam logic [FW-1:0] GAP_LAST   = FW'(COIN_GAP_FRAMES - 1);
  localparam logic [FW-1:0] F_ZERO     = FW'(0);
  localparam logic [FW-1:0] F_ONE      = FW'(1);

  localparam int QW = $clog2(COIN_QUEUE_MAX + 1);
  localparam logic [QW-1:0] Q_MAX  = QW'(COIN_QUEUE_MAX);
  localparam logic [QW-1:0] Q_ZERO = QW'(0);
  localparam logic [QW-1:0] Q_ONE  = QW'(1);

  logic [NBITS-1:0] w_raw;
  logic [NBITS-1:0] w_db;
  logic [3:0]       w_p1;
  logic [3:0]       w_p2;
  logic             w_unused_bits;

  logic             r_vblank_d;
  logic             r_coin_d;
  logic [QW-1:0]    r_queue;
  logic [FW-1:0]    r_fcnt;
  coin_state_t      r_state;
  logic [7:0]       r_in0;
  logic [7:0]       r_in1;
  logic             r_busy;

  logic             w_vblank_rise;
  logic             w_coin_edge;
  logic             w_pop;
  logic [QW-1:0]    w_queue_next;
  logic [FW-1:0]    w_fcnt_next;
  coin_state_t      w_state_next;

  assign w_raw = {I_JOY1[JOY_COIN], I_JOY1[JOY_S2], I_JOY1[JOY_S1],
                  I_JOY2[3:0], I_JOY1[3:0]};
  assign w_unused_bits = ^{I_JOY1[15:7], I_JOY2[15:4]};

  for (genvar g = 0; g < NBITS; g++) begin : g_db
    input_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .i_clk   (CLK),
      .i_rst_n (RESET_N),
      .i_raw   (w_raw[g]),
      .o_stable(w_db[g])
    );
  end

  // Opposing-direction cleaning on the debounced directions.
  always_comb begin
    w_p1 = {socd_pair(w_db[JOY_U], w_db[JOY_D]),
            socd_pair(w_db[JOY_L], w_db[JOY_R])};
    w_p2 = {socd_pair(w_db[4 + JOY_U], w_db[4 + JOY_D]),
            socd_pair(w_db[4 + JOY_L], w_db[4 + JOY_R])};
  end

  assign w_vblank_rise = I_VBLANK & ~r_vblank_d;
  assign w_coin_edge   = w_db[B_COIN] & ~r_coin_d;
  assign w_pop         = (r_state == C_IDLE) && (r_queue != Q_ZERO);

  // Pending-coin queue: saturating push on a press, pop when a pulse starts.
  always_comb begin
    w_queue_next = r_queue;
    case ({w_coin_edge, w_pop})
      2'b10: begin
        if (r_queue == Q_MAX) begin
          w_queue_next = r_queue;
        end else begin
          w_queue_next = r_queue + Q_ONE;
        end
      end
      2'b01:   w_queue_next = r_queue - Q_ONE;
      default: w_queue_next = r_queue;
    endcase
  end

  // Coin FSM next state; frames only advance on a VBLANK rising edge,
  // so a stuck VBLANK freezes the pulse at its current level.
  always_comb begin
    w_state_next = r_state;
    w_fcnt_next  = r_fcnt;
    case (r_state)
      C_IDLE: begin
        if (r_queue != Q_ZERO) begin
          w_state_next = C_PULSE;
          w_fcnt_next  = F_ZERO;
        end else begin
          w_state_next = C_IDLE;
        end
      end
      C_PULSE: begin
        if (w_vblank_rise) begin
          if (r_fcnt == PULSE_LAST) begin
            w_state_next = C_GAP;
            w_fcnt_next  = F_ZERO;
          end else begin
            w_fcnt_next  = r_fcnt + F_ONE;
          end
        end else begin
          w_fcnt_next = r_fcnt;
        end
      end
      C_GAP: begin
        if (w_vblank_rise) begin
          if (r_fcnt == GAP_LAST) begin
            w_state_next = C_IDLE;
            w_fcnt_next  = F_ZERO;
          end else begin
            w_fcnt_next  = r_fcnt + F_ONE;
          end
        end else begin
          w_fcnt_next = r_fcnt;
        end
      end
      default: begin
        w_state_next = C_IDLE;
        w_fcnt_next  = F_ZERO;
      end
    endcase
  end

  // State, queue and edge-detect registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= C_IDLE;
      r_fcnt     <= F_ZERO;
      r_queue    <= Q_ZERO;
      r_vblank_d <= 1'b0;
      r_coin_d   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_fcnt     <= w_fcnt_next;
      r_queue    <= w_queue_next;
      r_vblank_d <= I_VBLANK;
      r_coin_d   <= w_db[B_COIN];
    end
  end

  // Output registers; the coin bit is taken from the next state so it rises
  // together with the PULSE state and falls together with leaving it.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_in0  <= IN0_IDLE;
      r_in1  <= IN1_IDLE;
      r_busy <= 1'b0;
    end else begin
      r_in0  <= ~{w_p2, w_p1};
      r_in1  <= {1'b0, (w_state_next == C_PULSE), ~w_db[B_S2], ~w_db[B_S1], 4'b1111};
      r_busy <= (w_state_next != C_IDLE) || (w_queue_next != Q_ZERO);
    end
  end

  assign O_IN0       = r_in0;
  assign O_IN1       = r_in1;
  assign O_COIN_BUSY = r_busy;

endmodule

// File: tb/tb_crazy_input_cond.sv
// Directed bench for crazy_input_cond with DEBOUNCE_CYCLES=4, 3/3 coin
// frames and a 100-cycle VBLANK (high for the last 10 cycles of each period).
module tb_crazy_input_cond;

  localparam int LIM = 2000;

  logic        clk;
  logic        rst_n;
  logic [15:0] joy1;
  logic [15:0] joy2;
  logic        vblank;
  logic [7:0]  in0;
  logic [7:0]  in1;
  logic        busy;

  int n_checks;
  int n_fail;

  crazy_input_cond #(
    .DEBOUNCE_CYCLES  (4),
    .COIN_PULSE_FRAMES(3),
    .COIN_GAP_FRAMES  (3),
    .COIN_QUEUE_MAX   (3)
  ) dut (
    .CLK        (clk),
    .RESET_N    (rst_n),
    .I_JOY1     (joy1),
    .I_JOY2     (joy2),
    .I_VBLANK   (vblank),
    .O_IN0      (in0),
    .O_IN1      (in1),
    .O_COIN_BUSY(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // VBLANK: 90 cycles low, 10 cycles high, driven just after the clock edge.
  initial begin
    vblank = 1'b0;
    forever begin
      repeat (90) @(posedge clk);
      #1 vblank = 1'b1;
      repeat (10) @(posedge clk);
      #1 vblank = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_coin(input int hi, input int lo);
    @(posedge clk); #1 joy1[6] = 1'b1;
    repeat (hi) @(posedge clk);
    #1 joy1[6] = 1'b0;
    repeat (lo) @(posedge clk);
    #1;
  endtask

  // Park just after a VBLANK falling edge so the next rise is ~90 cycles away.
  task automatic wait_vb_fall();
    int g;
    g = 0;
    while (vblank !== 1'b1 && g < LIM) begin @(negedge clk); g++; end
    while (vblank !== 1'b0 && g < LIM) begin @(negedge clk); g++; end
    chk("vb_align", 8'(g < LIM), 8'd1);
    @(posedge clk); #1;
  endtask

  // Measure one coin pulse: VBLANK rises seen while the coin is high, rises
  // seen during the following low/busy gap, and whether another pulse follows.
  task automatic measure(output int hi, output int lo, output bit nxt, output bit ok);
    logic pv;
    logic r;
    int   g;
    hi = 0; lo = 0; nxt = 1'b0; ok = 1'b0; g = 0; pv = vblank; r = 1'b0;
    do begin
      @(negedge clk); r = vblank & ~pv; pv = vblank; g++;
    end while (in1[6] !== 1'b1 && g < LIM);
    if (in1[6] === 1'b1) begin
      if (r) hi++;
      g = 0;
      do begin
        @(negedge clk); r = vblank & ~pv; pv = vblank; g++;
        if (in1[6] === 1'b1 && r) hi++;
      end while (in1[6] === 1'b1 && g < LIM);
      if (in1[6] === 1'b0) begin
        if (busy === 1'b1 && r) lo++;
        g = 0;
        while (busy === 1'b1 && in1[6] === 1'b0 && g < LIM) begin
          @(negedge clk); r = vblank & ~pv; pv = vblank; g++;
          if (in1[6] === 1'b1) nxt = 1'b1;
          else if (busy === 1'b1 && r) lo++;
        end
        ok = (g < LIM);
      end
    end
  endtask

  initial begin
    int  dev;
    int  hi;
    int  lo;
    bit  nxt;
    bit  ok;

    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    joy1     = 16'h0000;
    joy2     = 16'h0000;

    cycles(3);
    chk("rst_in0", in0, 8'hFF);
    chk("rst_in1", in1, 8'h3F);
    chk("rst_busy", 8'(busy), 8'd0);
    rst_n = 1'b1;

    // Idle inputs keep the idle bytes indefinitely.
    dev = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((in0 !== 8'hFF || in1 !== 8'h3F || busy !== 1'b0) && dev < 255) dev++;
    end
    chk("idle_hold", 8'(dev), 8'd0);

    // P1 Up: visible exactly DEBOUNCE_CYCLES+1 = 5 cycles after the change.
    @(posedge clk); #1 joy1[3] = 1'b1;
    repeat (5) @(negedge clk);
    chk("up_before", in0, 8'hFF);
    @(negedge clk);
    chk("up_after", in0, 8'hF7);

    // 3-cycle glitch on Right never propagates.
    @(posedge clk); #1 joy1[0] = 1'b1;
    cycles(3);
    joy1[0] = 1'b0;
    cycles(10);
    chk("glitch", in0, 8'hF7);

    // Left+Right both held: both neutral.
    joy1[1:0] = 2'b11;
    cycles(10);
    chk("socd_lr", in0, 8'hF7);
    // Release Right: Left appears 5 cycles later.
    joy1[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk("left_before", in0, 8'hF7);
    @(negedge clk);
    chk("left_after", in0, 8'hF5);

    @(posedge clk); #1 joy1 = 16'h0000;
    cycles(10);
    chk("p1_clear", in0, 8'hFF);

    // P2: Up+Down cancel, Right active.
    joy2 = 16'h000D;
    cycles(10);
    chk("p2_socd_r", in0, 8'hEF);
    // Unused upper bits must have no effect.
    joy2 = 16'hFFFD;
    joy1 = 16'hFF80;
    cycles(10);
    chk("ignored_in0", in0, 8'hEF);
    chk("ignored_in1", in1, 8'h3F);
    joy1 = 16'h0000;
    joy2 = 16'h0000;
    cycles(10);

    // Starts.
    joy1[4] = 1'b1;
    cycles(10);
    chk("start1", in1, 8'h2F);
    joy1[5] = 1'b1;
    cycles(10);
    chk("start12", in1, 8'h0F);
    joy1 = 16'h0000;
    cycles(10);
    chk("start_clear", in1, 8'h3F);

    // Single coin press: one 3-frame pulse, then a 3-frame busy gap.
    wait_vb_fall();
    press_coin(20, 0);
    measure(hi, lo, nxt, ok);
    chk("c1_ok", 8'(ok), 8'd1);
    chk("c1_hi_frames", 8'(hi), 8'd3);
    chk("c1_gap_frames", 8'(lo), 8'd3);
    chk("c1_no_next", 8'(nxt), 8'd0);
    @(negedge clk);
    chk("c1_in1", in1, 8'h3F);
    chk("c1_busy", 8'(busy), 8'd0);

    // Five presses during one pulse: 1 running + 3 queued (saturated).
    wait_vb_fall();
    repeat (5) press_coin(5, 5);
    for (int k = 0; k < 4; k++) begin
      measure(hi, lo, nxt, ok);
      chk($sformatf("c5_ok_%0d", k), 8'(ok), 8'd1);
      chk($sformatf("c5_hi_%0d", k), 8'(hi), 8'd3);
      chk($sformatf("c5_gap_%0d", k), 8'(lo), 8'd3);
      chk($sformatf("c5_next_%0d", k), 8'(nxt), (k < 3) ? 8'd1 : 8'd0);
    end
    @(negedge clk);
    chk("c5_in1", in1, 8'h3F);
    chk("c5_busy", 8'(busy), 8'd0);

    // Reset mid-pulse with two presses still queued.
    wait_vb_fall();
    repeat (3) press_coin(5, 5);
    @(negedge clk);
    chk("rp_in1_pulse", in1, 8'h7F);
    chk("rp_busy", 8'(busy), 8'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rp_in1_async", in1, 8'h3F);
    chk("rp_busy_async", 8'(busy), 8'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    dev = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if ((in1[6] !== 1'b0 || busy !== 1'b0) && dev < 255) dev++;
    end
    chk("rp_no_pulses", 8'(dev), 8'd0);
    chk("rp_in1_end", in1, 8'h3F);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
